// File: rtl/pe_array_conv_if.sv
// pe_array_conv_if: control, memory-port and status bundle for the PE array convolution engine
interface pe_array_conv_if #(
    parameter int P  = 4,
    parameter int DW = 8,
    parameter int AW = 9,
    parameter int K  = 16
);
    localparam int ACC_W = 2 * DW + $clog2(K);
    logic              start;
    logic [AW-1:0]     X;
    logic [AW-1:0]     Y;
    logic [AW-1:0]     Z;
    logic [AW-1:0]     num_out;
    logic [3:0]        stride;
    logic [AW-1:0]     f_raddr;
    logic              f_ren;
    logic [DW-1:0]     f_rdata;
    logic [P*AW-1:0]   i_raddr;
    logic              i_ren;
    logic [P*DW-1:0]   i_rdata;
    logic [AW-1:0]     ofm_waddr;
    logic [ACC_W-1:0]  ofm_wdata;
    logic              ofm_we;
    logic              busy;
    logic              done;
    modport master (
        input  start, X, Y, Z, num_out, stride, f_rdata, i_rdata,
        output f_raddr, f_ren, i_raddr, i_ren, ofm_waddr, ofm_wdata, ofm_we, busy, done
    );
    modport slave (
        output start, X, Y, Z, num_out, stride, f_rdata, i_rdata,
        input  f_raddr, f_ren, i_raddr, i_ren, ofm_waddr, ofm_wdata, ofm_we, busy, done
    );
endinterface

// File: rtl/pe_array_conv.sv
// pe_array_conv: P-lane 1-D convolution, each lane a MAC over K taps, groups written out lane by lane
module pe_array_conv #(
    parameter int P  = 4,
    parameter int DW = 8,
    parameter int AW = 9,
    parameter int K  = 16
) (
    input logic clk,
    input logic rst,
    pe_array_conv_if.master bus
);
    localparam int ACC_W = 2 * DW + $clog2(K);
    localparam int KW = K > 1 ? $clog2(K) : 1;
    localparam int LW = P > 1 ? $clog2(P) : 1;
    localparam int GW = AW + 5;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    logic [2:0] state;
    logic [AW-1:0] yb, zb, n, lb;
    logic [3:0] st;
    logic [GW-1:0] gb, gi;
    logic [KW-1:0] k;
    logic [LW-1:0] wl;
    logic rd_v, last, fe, we;
    logic signed [ACC_W-1:0] acc [P];
    logic signed [2*DW-1:0] prod [P];
    assign gi = gb + GW'(wl);
    assign last = (wl == LW'(P - 1)) || (gi + GW'(1) >= GW'(n));
    assign fe = (state == FETCH) && !rst;
    assign we = (state == WRITE) && !rst;
    // per-lane signed product of the returned IFM word and the shared filter word
    always_comb begin
        for (int p = 0; p < P; p++)
            prod[p] = $signed(bus.i_rdata[p*DW +: DW]) * $signed(bus.f_rdata);
    end
    // sequencer, configuration latch and lane accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            yb <= '0;
            zb <= '0;
            n <= '0;
            lb <= '0;
            st <= '0;
            gb <= '0;
            k <= '0;
            wl <= '0;
            rd_v <= 1'b0;
            for (int p = 0; p < P; p++) acc[p] <= '0;
        end else begin
            rd_v <= state == FETCH;
            if (rd_v)
                for (int p = 0; p < P; p++) acc[p] <= acc[p] + ACC_W'(prod[p]);
            case (state)
                IDLE: if (bus.start) begin
                    yb <= bus.Y;
                    zb <= bus.Z;
                    n <= bus.num_out;
                    lb <= bus.X;
                    st <= bus.stride == 4'd0 ? 4'd1 : bus.stride;
                    gb <= '0;
                    k <= '0;
                    wl <= '0;
                    for (int p = 0; p < P; p++) acc[p] <= '0;
                    state <= bus.num_out == '0 ? DONE : FETCH;
                end
                FETCH: begin
                    k <= k == KW'(K - 1) ? '0 : k + KW'(1);
                    state <= k == KW'(K - 1) ? DRAIN : FETCH;
                end
                DRAIN: begin
                    wl <= '0;
                    state <= WRITE;
                end
                WRITE: begin
                    wl <= wl + LW'(1);
                    if (last && (gb + GW'(P) < GW'(n))) begin
                        gb <= gb + GW'(P);
                        lb <= lb + AW'(P) * AW'(st);
                        wl <= '0;
                        for (int p = 0; p < P; p++) acc[p] <= '0;
                        state <= FETCH;
                    end else if (last) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // memory-port and status outputs, all forced low while reset is asserted
    always_comb begin
        bus.f_ren = fe;
        bus.i_ren = fe;
        bus.f_raddr = fe ? yb + AW'(k) : '0;
        bus.i_raddr = '0;
        for (int p = 0; p < P; p++)
            bus.i_raddr[p*AW +: AW] = fe ? lb + AW'(p) * AW'(st) + AW'(k) : '0;
        bus.ofm_we = we;
        bus.ofm_waddr = we ? zb + AW'(gi) : '0;
        bus.ofm_wdata = we ? acc[wl] : '0;
        bus.busy = (state != IDLE) && !rst;
        bus.done = (state == DONE) && !rst;
    end
endmodule
